// File: rtl/weight_sram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// weight_sram_port_arbiter_if
//
// Purpose: bundles the request/grant handshake, both client command buses and
// the registered SRAM-side command bus of weight_sram_port_arbiter.
//
// Signals:
//   rd_req / wr_req        client requests (level sensitive)
//   rd_gnt / wr_gnt        grants, decoded from the registered arbiter state
//   rd_A, rd_CEN           read client addresses / chip enables (active low)
//   wr_A, wr_CEN, wr_WEN   write client addresses / chip enables / write enables
//   sram_A/CEN/WEN         registered command driven to the SRAM macros
//   rd_data_valid          SRAM Q carries data of a granted read
//   arb_state              0 IDLE, 1 READ, 2 TURN, 3 WRITE
//
// Modports: master = client side (drives requests and commands),
//           slave  = arbiter side.
// -----------------------------------------------------------------------------
interface weight_sram_port_arbiter_if #(
    parameter int N_BANK = 288,
    parameter int ADDR_W = 7
);
    logic                     rd_req;
    logic                     wr_req;
    logic                     rd_gnt;
    logic                     wr_gnt;
    logic [N_BANK*ADDR_W-1:0] rd_A;
    logic [N_BANK-1:0]        rd_CEN;
    logic [N_BANK*ADDR_W-1:0] wr_A;
    logic [N_BANK-1:0]        wr_CEN;
    logic [N_BANK-1:0]        wr_WEN;
    logic [N_BANK*ADDR_W-1:0] sram_A;
    logic [N_BANK-1:0]        sram_CEN;
    logic [N_BANK-1:0]        sram_WEN;
    logic                     rd_data_valid;
    logic [1:0]               arb_state;

    modport master (
        output rd_req, wr_req, rd_A, rd_CEN, wr_A, wr_CEN, wr_WEN,
        input  rd_gnt, wr_gnt, sram_A, sram_CEN, sram_WEN, rd_data_valid, arb_state
    );

    modport slave (
        input  rd_req, wr_req, rd_A, rd_CEN, wr_A, wr_CEN, wr_WEN,
        output rd_gnt, wr_gnt, sram_A, sram_CEN, sram_WEN, rd_data_valid, arb_state
    );
endinterface

// File: rtl/weight_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// weight_sram_port_arbiter
//
// Purpose: arbitrates the PE-array weight fetch (read client) and the weight
// loader (write client) onto N_BANK single-port weight SRAM macros. A
// request/grant FSM (IDLE/READ/TURN/WRITE) owns the bus; the granted client's
// command is registered towards the SRAMs; a shift register flags when SRAM Q
// holds data of a granted read.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          weight_sram_port_arbiter_if.slave (handshake + command buses)
//   perf_clr, perf_rd_cycles, perf_wr_cycles, perf_turn_cycles
//                only present when WEIGHT_ARB_PERF_CNT_EN is defined
//
// Optional feature macro: WEIGHT_ARB_PERF_CNT_EN adds three 32-bit wrapping
// activity counters with a synchronous clear.
// -----------------------------------------------------------------------------
module weight_sram_port_arbiter #(
    parameter int N_BANK    = 288,
    parameter int ADDR_W    = 7,
    parameter int RD_LAT    = 1,   // 1..4
    parameter int MAX_BURST = 16   // >= 1
) (
    input  logic clk,
    input  logic rst_n,
    weight_sram_port_arbiter_if.slave bus
`ifdef WEIGHT_ARB_PERF_CNT_EN
    ,
    input  logic        perf_clr,
    output logic [31:0] perf_rd_cycles,
    output logic [31:0] perf_wr_cycles,
    output logic [31:0] perf_turn_cycles
`endif
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_TURN  = 2'd2,
        ST_WRITE = 2'd3
    } arb_state_t;

    localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [2:0]         TURN_LAST  = 3'(RD_LAT - 1);

    arb_state_t               state_q, state_d;
    logic [BURST_W-1:0]       burst_q, burst_d;
    logic [2:0]               turn_q, turn_d;
    logic [N_BANK*ADDR_W-1:0] sram_a_q, sram_a_d;
    logic [N_BANK-1:0]        sram_cen_q, sram_cen_d;
    logic [N_BANK-1:0]        sram_wen_q, sram_wen_d;
    logic [RD_LAT:0]          rd_pipe_q, rd_pipe_d;
    logic                     rd_issue;

    // Next-state logic. Write wins a tie from IDLE so weights are loaded
    // before the PE array consumes them.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.wr_req)      state_d = ST_WRITE;
                else if (bus.rd_req) state_d = ST_READ;
            end
            ST_READ: begin
                if (!bus.rd_req)
                    state_d = bus.wr_req ? ST_TURN : ST_IDLE;
                else if (bus.wr_req && (burst_q == BURST_LAST))
                    state_d = ST_TURN;
            end
            ST_WRITE: begin
                // A write is finished once registered, so no turnaround here.
                if (!bus.wr_req)
                    state_d = bus.rd_req ? ST_READ : ST_IDLE;
                else if (bus.rd_req && (burst_q == BURST_LAST))
                    state_d = ST_READ;
            end
            ST_TURN: begin
                // Hold off the first write until in-flight reads have drained.
                if (turn_q == TURN_LAST) begin
                    if (bus.wr_req)      state_d = ST_WRITE;
                    else if (bus.rd_req) state_d = ST_READ;
                    else                 state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Burst and turnaround counters restart on every state change. The burst
    // counter only advances while the other client waits, so a lone client is
    // never preempted.
    always_comb begin
        burst_d = burst_q;
        turn_d  = turn_q;
        if (state_d != state_q) begin
            burst_d = '0;
            turn_d  = '0;
        end else begin
            if (((state_q == ST_READ) && bus.wr_req) ||
                ((state_q == ST_WRITE) && bus.rd_req)) begin
                if (burst_q != BURST_LAST)
                    burst_d = burst_q + BURST_W'(1);
            end
            if (state_q == ST_TURN)
                turn_d = turn_q + 3'd1;
        end
    end

    // SRAM command register. Outside READ/WRITE the macros are deselected and
    // the address is held to avoid needless toggling on the wide bus.
    always_comb begin
        sram_a_d   = sram_a_q;
        sram_cen_d = '1;
        sram_wen_d = '1;
        if (state_q == ST_READ) begin
            sram_a_d = bus.rd_A;
            if (bus.rd_req) sram_cen_d = bus.rd_CEN;
        end else if (state_q == ST_WRITE) begin
            sram_a_d   = bus.wr_A;
            sram_wen_d = bus.wr_WEN;
            if (bus.wr_req) sram_cen_d = bus.wr_CEN;
        end
    end

    // A read only produces data if at least one bank is actually enabled.
    assign rd_issue  = (state_q == ST_READ) && bus.rd_req && !(&bus.rd_CEN);
    assign rd_pipe_d = {rd_pipe_q[RD_LAT-1:0], rd_issue};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            burst_q    <= '0;
            turn_q     <= '0;
            sram_a_q   <= '0;
            sram_cen_q <= '1;
            sram_wen_q <= '1;
            rd_pipe_q  <= '0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            turn_q     <= turn_d;
            sram_a_q   <= sram_a_d;
            sram_cen_q <= sram_cen_d;
            sram_wen_q <= sram_wen_d;
            rd_pipe_q  <= rd_pipe_d;
        end
    end

    assign bus.rd_gnt        = (state_q == ST_READ);
    assign bus.wr_gnt        = (state_q == ST_WRITE);
    assign bus.sram_A        = sram_a_q;
    assign bus.sram_CEN      = sram_cen_q;
    assign bus.sram_WEN      = sram_wen_q;
    assign bus.rd_data_valid = rd_pipe_q[RD_LAT];
    assign bus.arb_state     = state_q;

`ifdef WEIGHT_ARB_PERF_CNT_EN
    logic [31:0] perf_rd_q, perf_rd_d;
    logic [31:0] perf_wr_q, perf_wr_d;
    logic [31:0] perf_turn_q, perf_turn_d;

    // Clear has priority; counters wrap naturally at 2^32.
    always_comb begin
        perf_rd_d   = perf_rd_q + 32'((state_q == ST_READ) && bus.rd_req);
        perf_wr_d   = perf_wr_q + 32'((state_q == ST_WRITE) && bus.wr_req);
        perf_turn_d = perf_turn_q + 32'(state_q == ST_TURN);
        if (perf_clr) begin
            perf_rd_d   = '0;
            perf_wr_d   = '0;
            perf_turn_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_rd_q   <= '0;
            perf_wr_q   <= '0;
            perf_turn_q <= '0;
        end else begin
            perf_rd_q   <= perf_rd_d;
            perf_wr_q   <= perf_wr_d;
            perf_turn_q <= perf_turn_d;
        end
    end

    assign perf_rd_cycles   = perf_rd_q;
    assign perf_wr_cycles   = perf_wr_q;
    assign perf_turn_cycles = perf_turn_q;
`endif
endmodule

// File: tb/tb_weight_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_weight_sram_port_arbiter
//
// Directed bench for weight_sram_port_arbiter with N_BANK=4, ADDR_W=7,
// RD_LAT=2, MAX_BURST=4. A vector table drives one clock edge per record and
// compares state, grants, SRAM command and read-valid against hand-computed
// values; short hand-written sequences cover tie fairness and async reset.
// -----------------------------------------------------------------------------
module tb_weight_sram_port_arbiter;
    localparam int NB = 4;
    localparam int AW = 7;

    logic clk;
    logic rst_n;

    weight_sram_port_arbiter_if #(.N_BANK(NB), .ADDR_W(AW)) bus ();

`ifdef WEIGHT_ARB_PERF_CNT_EN
    logic        perf_clr;
    logic [31:0] perf_rd_cycles;
    logic [31:0] perf_wr_cycles;
    logic [31:0] perf_turn_cycles;
`endif

    weight_sram_port_arbiter #(
        .N_BANK(NB), .ADDR_W(AW), .RD_LAT(2), .MAX_BURST(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef WEIGHT_ARB_PERF_CNT_EN
        ,
        .perf_clr         (perf_clr),
        .perf_rd_cycles   (perf_rd_cycles),
        .perf_wr_cycles   (perf_wr_cycles),
        .perf_turn_cycles (perf_turn_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd_req;
        logic        wr_req;
        logic [6:0]  rd_a;
        logic [3:0]  rd_cen;
        logic [6:0]  wr_a;
        logic [3:0]  wr_cen;
        logic [3:0]  wr_wen;
        logic [1:0]  exp_st;
        logic [27:0] exp_a;
        logic [3:0]  exp_cen;
        logic [3:0]  exp_wen;
        logic        exp_vld;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Bank i carries base+i so that bank ordering errors are visible.
    function automatic logic [27:0] mk(input logic [6:0] a);
        logic [27:0] r;
        for (int i = 0; i < NB; i++) r[i*AW +: AW] = a + 7'(i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rr, input logic wr, input logic [6:0] ra,
                       input logic [3:0] rcen, input logic [6:0] wa,
                       input logic [3:0] wcen, input logic [3:0] wwen,
                       input logic [1:0] est, input logic [27:0] ea,
                       input logic [3:0] ecen, input logic [3:0] ewen, input logic evld);
        vec_t v;
        v.rd_req = rr;   v.wr_req = wr;   v.rd_a = ra;     v.rd_cen = rcen;
        v.wr_a = wa;     v.wr_cen = wcen; v.wr_wen = wwen;
        v.exp_st = est;  v.exp_a = ea;    v.exp_cen = ecen;
        v.exp_wen = ewen; v.exp_vld = evld;
        vecs.push_back(v);
    endtask

    task automatic chk_outputs(input string tag, input logic [1:0] est, input logic [27:0] ea,
                               input logic [3:0] ecen, input logic [3:0] ewen, input logic evld);
        chk({tag, " state"},  64'(bus.arb_state),     64'(est));
        chk({tag, " rd_gnt"}, 64'(bus.rd_gnt),        64'(est == 2'd1));
        chk({tag, " wr_gnt"}, 64'(bus.wr_gnt),        64'(est == 2'd3));
        chk({tag, " A"},      64'(bus.sram_A),        64'(ea));
        chk({tag, " CEN"},    64'(bus.sram_CEN),      64'(ecen));
        chk({tag, " WEN"},    64'(bus.sram_WEN),      64'(ewen));
        chk({tag, " vld"},    64'(bus.rd_data_valid), 64'(evld));
    endtask

    initial begin
        // rr wr  ra  rcen  wa  wcen  wwen | st  A         CEN   WEN   vld
        add(0, 1, 0,  4'hF, 5,  4'hE, 4'hE,  3, 28'd0,     4'hF, 4'hF, 0); // IDLE->WRITE, tie-free
        add(0, 1, 0,  4'hF, 5,  4'hE, 4'hE,  3, mk(5),     4'hE, 4'hE, 0); // write registered
        add(0, 0, 0,  4'hF, 5,  4'hE, 4'hE,  0, mk(5),     4'hF, 4'hE, 0); // drop: CEN gated
        add(1, 0, 9,  4'h3, 5,  4'hF, 4'hF,  1, mk(5),     4'hF, 4'hF, 0); // IDLE->READ, A held
        add(1, 0, 9,  4'h3, 5,  4'hF, 4'hF,  1, mk(9),     4'h3, 4'hF, 0); // read issued
        add(0, 0, 9,  4'h3, 5,  4'hF, 4'hF,  0, mk(9),     4'hF, 4'hF, 0); // drop -> IDLE
        add(0, 0, 9,  4'h3, 5,  4'hF, 4'hF,  0, mk(9),     4'hF, 4'hF, 1); // valid at t+3
        add(0, 0, 9,  4'h3, 5,  4'hF, 4'hF,  0, mk(9),     4'hF, 4'hF, 0); // single pulse
        add(1, 0, 20, 4'hF, 5,  4'hF, 4'hF,  1, mk(9),     4'hF, 4'hF, 0);
        add(1, 0, 20, 4'hF, 5,  4'hF, 4'hF,  1, mk(20),    4'hF, 4'hF, 0); // all banks off
        add(0, 0, 20, 4'hF, 5,  4'hF, 4'hF,  0, mk(20),    4'hF, 4'hF, 0);
        add(0, 0, 20, 4'hF, 5,  4'hF, 4'hF,  0, mk(20),    4'hF, 4'hF, 0); // no valid
        add(0, 0, 20, 4'hF, 5,  4'hF, 4'hF,  0, mk(20),    4'hF, 4'hF, 0);
        add(1, 0, 33, 4'h0, 40, 4'hF, 4'hF,  1, mk(20),    4'hF, 4'hF, 0);
        add(0, 1, 33, 4'h0, 40, 4'hE, 4'hD,  2, mk(33),    4'hF, 4'hF, 0); // READ->TURN
        add(0, 1, 33, 4'h0, 40, 4'hE, 4'hD,  2, mk(33),    4'hF, 4'hF, 0); // TURN 2nd cycle
        add(0, 1, 33, 4'h0, 40, 4'hE, 4'hD,  3, mk(33),    4'hF, 4'hF, 0); // TURN->WRITE
        add(0, 1, 33, 4'h0, 40, 4'hE, 4'hD,  3, mk(40),    4'hE, 4'hD, 0);
        add(0, 0, 33, 4'h0, 40, 4'hE, 4'hD,  0, mk(40),    4'hF, 4'hD, 0);

`ifdef WEIGHT_ARB_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        // Reset with random inputs.
        rst_n       = 1'b0;
        bus.rd_req  = 1'($urandom);
        bus.wr_req  = 1'($urandom);
        bus.rd_A    = 28'($urandom);
        bus.wr_A    = 28'($urandom);
        bus.rd_CEN  = 4'($urandom);
        bus.wr_CEN  = 4'($urandom);
        bus.wr_WEN  = 4'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk_outputs("reset", 2'd0, 28'd0, 4'hF, 4'hF, 1'b0);
        $display("reset: st=%0d CEN=%b WEN=%b vld=%b", bus.arb_state, bus.sram_CEN,
                 bus.sram_WEN, bus.rd_data_valid);
        rst_n = 1'b1;

        // Table-driven vectors: one edge per record.
        for (int i = 0; i < vecs.size(); i++) begin
            bus.rd_req = vecs[i].rd_req;
            bus.wr_req = vecs[i].wr_req;
            bus.rd_A   = mk(vecs[i].rd_a);
            bus.rd_CEN = vecs[i].rd_cen;
            bus.wr_A   = mk(vecs[i].wr_a);
            bus.wr_CEN = vecs[i].wr_cen;
            bus.wr_WEN = vecs[i].wr_wen;
            @(posedge clk);
            #1;
            chk_outputs($sformatf("vec%0d", i), vecs[i].exp_st, vecs[i].exp_a,
                        vecs[i].exp_cen, vecs[i].exp_wen, vecs[i].exp_vld);
            $display("vec %0d: st=%0d A=%h CEN=%b WEN=%b vld=%b", i, bus.arb_state,
                     bus.sram_A, bus.sram_CEN, bus.sram_WEN, bus.rd_data_valid);
        end

        // Tie and fairness: WRITE x4, READ x4, TURN x2, repeating.
        bus.rd_req = 1'b1; bus.wr_req = 1'b1;
        bus.rd_CEN = 4'h0; bus.wr_CEN = 4'hE; bus.wr_WEN = 4'hE;
        for (int k = 0; k < 20; k++) begin
            logic [1:0] est;
            est = ((k % 10) < 4) ? 2'd3 : (((k % 10) < 8) ? 2'd1 : 2'd2);
            @(posedge clk);
            #1;
            chk($sformatf("fair%0d state", k), 64'(bus.arb_state), 64'(est));
            $display("fair %0d: st=%0d", k, bus.arb_state);
        end
        bus.rd_req = 1'b0; bus.wr_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("fair idle state", 64'(bus.arb_state), 64'd0);

        // Reset during a read: in-flight valid bits must be discarded.
        bus.rd_req = 1'b1; bus.rd_CEN = 4'h0; bus.rd_A = mk(60);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rdrst rd_gnt", 64'(bus.rd_gnt), 64'd0);
        chk("rdrst CEN", 64'(bus.sram_CEN), 64'hF);
        bus.rd_req = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rdrst vld%0d", k), 64'(bus.rd_data_valid), 64'd0);
            $display("rdrst %0d: vld=%b", k, bus.rd_data_valid);
        end

        // Async reset mid-WRITE, then recovery after one edge.
        bus.wr_req = 1'b1; bus.wr_A = mk(7); bus.wr_CEN = 4'hE; bus.wr_WEN = 4'hE;
        repeat (2) @(posedge clk);
        #1;
        chk("wrrst pre CEN", 64'(bus.sram_CEN), 64'hE);
        chk("wrrst pre wr_gnt", 64'(bus.wr_gnt), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("wrrst CEN", 64'(bus.sram_CEN), 64'hF);
        chk("wrrst WEN", 64'(bus.sram_WEN), 64'hF);
        chk("wrrst wr_gnt", 64'(bus.wr_gnt), 64'd0);
        chk("wrrst state", 64'(bus.arb_state), 64'd0);
        $display("wrrst: st=%0d CEN=%b WEN=%b", bus.arb_state, bus.sram_CEN, bus.sram_WEN);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("wrrst recover wr_gnt", 64'(bus.wr_gnt), 64'd1);
        $display("wrrst recover: wr_gnt=%b", bus.wr_gnt);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
